id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Instruction-decode stage. Sits between fetch and id_ex_stage, and drives every *_id input of that register.
//  Decodes an 18-bit instruction into control bits and reads the 8x32 register file; WB writes the file.
//  Detects load-use hazards and inserts bubbles (stall_if) into the pipeline.
//  Holds the HALT state machine.
// PARAMETERS
//  pc_width    10  program counter width
//  func_width   6  function field width
//  const_width  8  immediate width
//  index_width  3  register index width (2**index_width registers)
//  reg_width   32  register data width
//  instr_width 18  instruction width
// PORTS
//  clk         in   1            rising-edge clock
//  rst         in   1            asynchronous reset, active high
//  instr_valid in   1            fetch presents a valid instruction
//  instr       in   instr_width  [17:12] func, [11:9] op0, [8:6] op1, [5:3] op2, [7:0] const
//  pc_curr_if  in   pc_width     PC of instr
//  wb_en       in   1            register-file write enable (from WB)
//  wb_idx      in   index_width  write index
//  wb_data     in   reg_width    write data
//  memRead_ex  in   1            instruction in EX is a LOAD
//  op0_ex      in   index_width  destination of the instruction in EX
//  pc_curr_id, func_id, const_id, memRead_id, memWrite_id, aluToReg_id, constToReg_id,
//  aluEn_id, halt_id, regWrite_id, op0_id, S1_id, S2_id  out  (widths as id_ex_stage)  decoded fields
//  stall_if    out  1            fetch holds PC and instr this cycle
//  halted      out  1            core is in HALTED state
// BEHAVIOUR
//  Reset: state=RUN, all registers=0, halted=0, stall_if=0. Outputs during rst are a bubble.
//  Bubble: every control bit is 0 (memRead/memWrite/aluToReg/constToReg/aluEn/halt/regWrite).
//   func_id=0, const_id=0, op0_id=0.
//   S1_id, S2_id and pc_curr_id still follow the inputs, which is harmless.
//  Decode is combinational; id_ex_stage provides the pipeline register, so latency to EX is 1 clk.
//  Per func:
//   func[5:4]==00 ALU: aluEn, aluToReg, regWrite; S1=R[op1], S2=R[op2].
//   6'h10 LOAD: memRead, regWrite; S1=R[op1] (address).
//   6'h11 STORE: memWrite; S1=R[op1] (address), S2=R[op0] (data).
//   6'h12 LOADC: constToReg, regWrite; const_id=instr[7:0].
//   6'h3F HALT: halt_id.
//   any other func: NOP, i.e. a bubble with func_id passed through.
//  Sources used: ALU {op1,op2}; LOAD {op1}; STORE {op1,op0}; LOADC and HALT none.
//  Load-use hazard: memRead_ex=1, instr_valid=1, and op0_ex equals a used source.
//   Response: stall_if=1 and a bubble is emitted for that cycle.
//   The next cycle re-evaluates; the LOAD has then left EX, so the instruction issues.
//  instr_valid=0: bubble, stall_if=0.
//  Register file: write on posedge clk when wb_en. Index 0 is an ordinary register (writable).
//  FSM RUN -> HALTED: taken when HALT is decoded, instr_valid=1 and no stall.
//   halt_id=1 for exactly that one cycle.
//  HALTED: stall_if=1 and bubbles permanently. Register-file writes from wb_en still complete.
//   Exit only through rst.
//  rst mid-operation: asynchronous return to the reset state; any pending stall is dropped.
// CONFIGURATION
//  WB_BYPASS_EN defined: a read index equal to wb_idx with wb_en=1 returns wb_data in the same cycle.
//   No stall is taken for this case.
//  WB_BYPASS_EN undefined: reads return the stored value.
//   A used source equal to wb_idx with wb_en=1 forces stall_if=1 plus a bubble for that cycle.
//   This WB stall ORs with the load-use stall.
// TESTING
//  1 Reset: rst=1 at mid-cycle -> all controls 0, halted=0, R0..R7=0 after release.
//  2 ALU: R1=5, R2=7; instr func=0x01 op0=3 op1=1 op2=2
//    -> aluEn=aluToReg=regWrite=1, S1_id=5, S2_id=7, op0_id=3, stall_if=0.
//  3 Load-use: memRead_ex=1, op0_ex=2; ALU instr reading op2=2
//    -> stall_if=1 and a bubble for 1 cycle, then issues with stall_if=0.
//    Repeat with STORE op0=2 -> same stall.
//  4 WB collision: wb_en=1, wb_idx=1, wb_data=0xDEADBEEF; ALU reads op1=1
//    -> with WB_BYPASS_EN: S1_id=0xDEADBEEF, no stall.
//    -> without it: 1 stall cycle, then S1_id=0xDEADBEEF.
//  5 LOADC: func=0x12, op0=4, const=0xA5 -> constToReg=regWrite=1, const_id=0xA5.
//    No stall even when memRead_ex=1 and op0_ex=4.
//  6 HALT: func=0x3F -> halt_id=1 for 1 clk, then halted=1, stall_if=1 and bubbles.
//    A later wb write to R5=9 still lands (visible after rst? no: checked via a backdoor read).
//    rst -> RUN.

Source files
------------

// File: rtl/id_stage.sv
// Instruction decode: field decode, 8x32 register file, hazard stalls, HALT FSM.
// Optional WB_BYPASS_EN: forward same-cycle WB data instead of stalling on it.
module id_stage #(
  parameter int pc_width    = 10,
  parameter int func_width  = 6,
  parameter int const_width = 8,
  parameter int index_width = 3,
  parameter int reg_width   = 32,
  parameter int instr_width = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  input  logic [instr_width-1:0] instr,
  input  logic [pc_width-1:0]    pc_curr_if,
  input  logic                   wb_en,
  input  logic [index_width-1:0] wb_idx,
  input  logic [reg_width-1:0]   wb_data,
  input  logic                   memRead_ex,
  input  logic [index_width-1:0] op0_ex,
  output logic [pc_width-1:0]    pc_curr_id,
  output logic [func_width-1:0]  func_id,
  output logic [const_width-1:0] const_id,
  output logic                   memRead_id,
  output logic                   memWrite_id,
  output logic                   aluToReg_id,
  output logic                   constToReg_id,
  output logic                   aluEn_id,
  output logic                   halt_id,
  output logic                   regWrite_id,
  output logic [index_width-1:0] op0_id,
  output logic [reg_width-1:0]   S1_id,
  output logic [reg_width-1:0]   S2_id,
  output logic                   stall_if,
  output logic                   halted
);

  localparam int NREG    = 1 << index_width;
  localparam int OP0_LSB = instr_width - func_width - index_width;
  localparam int OP1_LSB = OP0_LSB - index_width;
  localparam int OP2_LSB = OP1_LSB - index_width;

  localparam logic [func_width-1:0] F_LOAD  = func_width'(6'h10);
  localparam logic [func_width-1:0] F_STORE = func_width'(6'h11);
  localparam logic [func_width-1:0] F_LOADC = func_width'(6'h12);
  localparam logic [func_width-1:0] F_HALT  = func_width'(6'h3F);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t               r_state;
  logic [reg_width-1:0] r_regs [NREG];

  logic [func_width-1:0]  w_func;
  logic [index_width-1:0] w_op0;
  logic [index_width-1:0] w_op1;
  logic [index_width-1:0] w_op2;
  logic [const_width-1:0] w_const;
  logic                   w_is_alu;
  logic                   w_is_ld;
  logic                   w_is_st;
  logic                   w_is_ldc;
  logic                   w_is_hlt;
  logic                   w_use0;
  logic                   w_use1;
  logic                   w_use2;
  logic                   w_uses_ex;
  logic                   w_lu_stall;
  logic                   w_wb_stall;
  logic                   w_halted;
  logic                   w_issue;
  logic [reg_width-1:0]   w_rd0;
  logic [reg_width-1:0]   w_rd1;
  logic [reg_width-1:0]   w_rd2;

  assign w_func  = instr[instr_width-1 -: func_width];
  assign w_op0   = instr[OP0_LSB +: index_width];
  assign w_op1   = instr[OP1_LSB +: index_width];
  assign w_op2   = instr[OP2_LSB +: index_width];
  assign w_const = instr[const_width-1:0];

  assign w_is_alu = (w_func[func_width-1 -: 2] == 2'b00);
  assign w_is_ld  = (w_func == F_LOAD);
  assign w_is_st  = (w_func == F_STORE);
  assign w_is_ldc = (w_func == F_LOADC);
  assign w_is_hlt = (w_func == F_HALT);

  assign w_use0 = w_is_st;
  assign w_use1 = w_is_alu | w_is_ld | w_is_st;
  assign w_use2 = w_is_alu;

  assign w_uses_ex = (w_use0 && w_op0 == op0_ex) ||
                     (w_use1 && w_op1 == op0_ex) ||
                     (w_use2 && w_op2 == op0_ex);
  assign w_lu_stall = instr_valid && memRead_ex && w_uses_ex;

`ifdef WB_BYPASS_EN
  assign w_rd0 = (wb_en && wb_idx == w_op0) ? wb_data : r_regs[w_op0];
  assign w_rd1 = (wb_en && wb_idx == w_op1) ? wb_data : r_regs[w_op1];
  assign w_rd2 = (wb_en && wb_idx == w_op2) ? wb_data : r_regs[w_op2];
  assign w_wb_stall = 1'b0;
`else
  logic w_uses_wb;
  assign w_rd0 = r_regs[w_op0];
  assign w_rd1 = r_regs[w_op1];
  assign w_rd2 = r_regs[w_op2];
  assign w_uses_wb = (w_use0 && w_op0 == wb_idx) ||
                     (w_use1 && w_op1 == wb_idx) ||
                     (w_use2 && w_op2 == wb_idx);
  assign w_wb_stall = instr_valid && wb_en && w_uses_wb;
`endif

  assign w_halted = (r_state == S_HALTED);
  assign w_issue  = !rst && instr_valid && !w_halted &&
                    !w_lu_stall && !w_wb_stall;

  assign stall_if   = !rst && (w_halted || w_lu_stall || w_wb_stall);
  assign halted     = w_halted;
  assign pc_curr_id = pc_curr_if;
  assign S1_id      = w_rd1;
  assign S2_id      = w_is_st ? w_rd0 : w_rd2;

  always_comb begin
    func_id       = '0;
    const_id      = '0;
    op0_id        = '0;
    memRead_id    = 1'b0;
    memWrite_id   = 1'b0;
    aluToReg_id   = 1'b0;
    constToReg_id = 1'b0;
    aluEn_id      = 1'b0;
    halt_id       = 1'b0;
    regWrite_id   = 1'b0;
    if (w_issue) begin
      func_id = w_func;
      unique case (1'b1)
        w_is_alu: begin
          op0_id      = w_op0;
          aluEn_id    = 1'b1;
          aluToReg_id = 1'b1;
          regWrite_id = 1'b1;
        end
        w_is_ld: begin
          op0_id      = w_op0;
          memRead_id  = 1'b1;
          regWrite_id = 1'b1;
        end
        w_is_st: begin
          op0_id      = w_op0;
          memWrite_id = 1'b1;
        end
        w_is_ldc: begin
          op0_id        = w_op0;
          const_id      = w_const;
          constToReg_id = 1'b1;
          regWrite_id   = 1'b1;
        end
        w_is_hlt: begin
          op0_id  = w_op0;
          halt_id = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // WB writes land even while halted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (wb_en) begin
      r_regs[wb_idx] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      unique case (r_state)
        S_RUN:    if (w_issue && w_is_hlt) r_state <= S_HALTED;
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage against an instruction-level reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [17:0] instr;
  logic [9:0]  pc_curr_if;
  logic        wb_en;
  logic [2:0]  wb_idx;
  logic [31:0] wb_data;
  logic        memRead_ex;
  logic [2:0]  op0_ex;
  logic [9:0]  pc_curr_id;
  logic [5:0]  func_id;
  logic [7:0]  const_id;
  logic        memRead_id, memWrite_id, aluToReg_id, constToReg_id;
  logic        aluEn_id, halt_id, regWrite_id;
  logic [2:0]  op0_id;
  logic [31:0] S1_id, S2_id;
  logic        stall_if, halted;

  id_stage dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .pc_curr_if(pc_curr_if), .wb_en(wb_en), .wb_idx(wb_idx),
    .wb_data(wb_data), .memRead_ex(memRead_ex), .op0_ex(op0_ex),
    .pc_curr_id(pc_curr_id), .func_id(func_id), .const_id(const_id),
    .memRead_id(memRead_id), .memWrite_id(memWrite_id),
    .aluToReg_id(aluToReg_id), .constToReg_id(constToReg_id),
    .aluEn_id(aluEn_id), .halt_id(halt_id), .regWrite_id(regWrite_id),
    .op0_id(op0_id), .S1_id(S1_id), .S2_id(S2_id),
    .stall_if(stall_if), .halted(halted)
  );

  always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [8];
  bit          m_halted;
  bit          m_issue;
  bit          m_is_hlt;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {memRead_id, memWrite_id, aluToReg_id, constToReg_id,
            aluEn_id, halt_id, regWrite_id};
  endfunction

  function automatic logic [31:0] mread(input logic [2:0] i);
    if (BYP && wb_en && wb_idx == i) return wb_data;
    return m_regs[i];
  endfunction

  // Compare every output against the model for the current inputs
  task automatic settle_check();
    logic [5:0] f;
    logic [2:0] a0, a1, a2;
    bit alu, ld, st, ldc, hlt, haz;
    logic [6:0] ectl;
    #1;
    f = instr[17:12]; a0 = instr[11:9]; a1 = instr[8:6]; a2 = instr[5:3];
    alu = (f < 6'h10); ld = (f == 6'h10); st = (f == 6'h11);
    ldc = (f == 6'h12); hlt = (f == 6'h3F);
    haz = 0;
    for (int s = 0; s < 8; s++) begin
      bit used;
      used = (alu && (a1 == s || a2 == s)) || (ld && a1 == s) ||
             (st && (a1 == s || a0 == s));
      if (used && memRead_ex && op0_ex == s) haz = 1;
      if (used && !BYP && wb_en && wb_idx == s) haz = 1;
    end
    haz = haz && instr_valid;
    m_issue = instr_valid && !m_halted && !haz;
    m_is_hlt = hlt;
    ectl = 7'b0;
    if (m_issue) begin
      if (alu) ectl = 7'b0010101;
      if (ld)  ectl = 7'b1000001;
      if (st)  ectl = 7'b0100000;
      if (ldc) ectl = 7'b0001001;
      if (hlt) ectl = 7'b0000010;
    end
    check("stall", stall_if, m_halted || haz);
    check("halted", halted, m_halted);
    check("ctrl", ctrl_vec(), ectl);
    check("func", func_id, m_issue ? f : 6'h0);
    check("op0", op0_id,
          (m_issue && (alu || ld || st || ldc || hlt)) ? a0 : 3'd0);
    check("const", const_id, (m_issue && ldc) ? instr[7:0] : 8'h0);
    check("pc", pc_curr_id, pc_curr_if);
    if (m_issue && (alu || ld || st)) check("S1", S1_id, mread(a1));
    if (m_issue && alu) check("S2", S2_id, mread(a2));
    if (m_issue && st) check("S2st", S2_id, mread(a0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (wb_en) m_regs[wb_idx] = wb_data;
    if (m_issue && m_is_hlt) m_halted = 1;
    @(negedge clk);
  endtask

  task automatic idle();
    instr_valid = 0; instr = '0; wb_en = 0; wb_idx = 0; wb_data = 0;
    memRead_ex = 0; op0_ex = 0;
  endtask

  task automatic do_reset();
    idle();
    #3 rst = 1;
    #1;
    check("rst_ctrl", ctrl_vec(), 7'b0);
    check("rst_stall", stall_if, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_func", func_id, 6'h0);
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_halted = 0;
    @(negedge clk);
    rst = 0;
  endtask

  function automatic logic [17:0] mk(input logic [5:0] f,
      input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
    return {f, a0, a1, a2, 3'b0};
  endfunction

  initial begin
    idle();
    pc_curr_if = 0;
    rst = 1;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_halted = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    do_reset();

    // Registers read back as zero after reset
    for (int i = 0; i < 8; i++) begin
      instr_valid = 1; instr = mk(6'h00, 3'd0, 3'(i), 3'(i));
      settle_check();
      check("r_zero", S1_id, 32'h0);
      tick();
    end

    // ALU
    idle(); wb_en = 1; wb_idx = 1; wb_data = 5; settle_check(); tick();
    wb_idx = 2; wb_data = 7; settle_check(); tick();
    idle(); instr_valid = 1; instr = mk(6'h01, 3'd3, 3'd1, 3'd2);
    settle_check();
    check("alu_S1", S1_id, 32'd5);
    check("alu_S2", S2_id, 32'd7);
    check("alu_ctl", ctrl_vec(), 7'b0010101);
    tick();

    // Load-use on ALU op2 and STORE op0
    memRead_ex = 1; op0_ex = 2;
    settle_check(); check("lu_stall", stall_if, 1'b1); tick();
    memRead_ex = 0; settle_check(); check("lu_go", stall_if, 1'b0); tick();
    memRead_ex = 1; instr = mk(6'h11, 3'd2, 3'd3, 3'd0);
    settle_check(); check("lu_st", stall_if, 1'b1); tick();
    memRead_ex = 0; settle_check(); check("st_go", memWrite_id, 1'b1); tick();

    // WB collision
    instr = mk(6'h01, 3'd3, 3'd1, 3'd2);
    wb_en = 1; wb_idx = 1; wb_data = 32'hDEADBEEF;
    settle_check();
`ifdef WB_BYPASS_EN
    check("byp_S1", S1_id, 32'hDEADBEEF);
    check("byp_nostall", stall_if, 1'b0);
    tick();
`else
    check("wb_stall", stall_if, 1'b1);
    tick();
    wb_en = 0; settle_check();
    check("wb_S1", S1_id, 32'hDEADBEEF);
    check("wb_go", stall_if, 1'b0);
    tick();
`endif
    wb_en = 0;

    // LOADC ignores load-use
    memRead_ex = 1; op0_ex = 4; instr = {6'h12, 4'b1000, 8'hA5};
    settle_check();
    check("ldc_const", const_id, 8'hA5);
    check("ldc_stall", stall_if, 1'b0);
    tick();

    // HALT
    idle(); instr_valid = 1; instr = mk(6'h3F, 3'd0, 3'd0, 3'd0);
    settle_check(); check("halt_id", halt_id, 1'b1); tick();
    instr = mk(6'h01, 3'd1, 3'd1, 3'd2);
    wb_en = 1; wb_idx = 5; wb_data = 9;
    settle_check(); check("halted", halted, 1'b1); tick();
    wb_en = 0;
    check("halt_wb", dut.r_regs[5], 32'd9);
    settle_check(); check("halt_hold", halt_id, 1'b0); tick();
    do_reset();
    settle_check(); check("run_again", halted, 1'b0); tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] f;
      int k;
      k = $urandom_range(0, 15);
      if (k <= 5) f = 6'($urandom_range(0, 15));
      else if (k <= 7) f = 6'h10;
      else if (k <= 9) f = 6'h11;
      else if (k <= 11) f = 6'h12;
      else if (k == 12) f = 6'($urandom_range(6'h13, 6'h3E));
      else if (k == 13 && $urandom_range(0, 19) == 0) f = 6'h3F;
      else f = 6'($urandom_range(0, 15));
      instr_valid = ($urandom_range(0, 7) != 0);
      instr = {f, 12'($urandom)};
      pc_curr_if = 10'($urandom);
      wb_en = $urandom_range(0, 2) == 0;
      wb_idx = 3'($urandom);
      wb_data = $urandom;
      memRead_ex = $urandom_range(0, 2) == 0;
      op0_ex = 3'($urandom);
      settle_check();
      tick();
      if ((m_halted && $urandom_range(0, 9) == 0) ||
          $urandom_range(0, 499) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
